fma16_mul_stage: RTL



---
 rtl/fma16_mul_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fma16_mul_stage.sv
// FMA16 iterative shift-and-add significand multiplier (x significand times y significand).
// Define FMA16_MUL_EARLY_TERM_EN to leave BUSY as soon as the remaining multiplier bits are zero.
module fma16_mul_stage #(
   parameter int BITS_PER_CYC = 1,
   parameter int BIAS         = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        xs,
   input  logic        ys,
   input  logic [4:0]  xe,
   input  logic [4:0]  ye,
   input  logic [9:0]  xm,
   input  logic [9:0]  ym,
   input  logic        x_zero,
   input  logic        y_zero,
   input  logic        x_inf,
   input  logic        y_inf,
   input  logic        x_nan,
   input  logic        y_nan,
   input  logic        negp,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        ps,
   output logic [6:0]  pe,
   output logic [21:0] pm,
   output logic        p_zero,
   output logic        p_inf,
   output logic        p_nan,
   output logic        p_invalid
);

   localparam int         N      = 11 / BITS_PER_CYC;
   localparam logic [3:0] N_LD   = 4'(N);
   localparam logic [6:0] BIAS_W = 7'(BIAS);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic [21:0] mcand;
   logic [10:0] mplr;

   logic        accept;
   logic        special;
   logic        last;
   logic        nan_c;
   logic        inv_c;
   logic        inf_c;
   logic        zero_c;
   logic [10:0] xsig;
   logic [10:0] ysig;
   logic [6:0]  xe_eff;
   logic [6:0]  ye_eff;
   logic [21:0] acc_nxt;
   logic [21:0] mcand_nxt;
   logic [10:0] mplr_nxt;

   assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
   assign out_valid = (state == DONE);
   assign accept    = in_valid & in_ready;

   assign special = x_zero | y_zero | x_inf | y_inf | x_nan | y_nan;

   assign xsig   = {xe != 5'd0, xm};
   assign ysig   = {ye != 5'd0, ym};
   assign xe_eff = (xe == 5'd0) ? 7'd1 : {2'b00, xe};
   assign ye_eff = (ye == 5'd0) ? 7'd1 : {2'b00, ye};

   // Special-case flags resolved in priority order: NaN, invalid, inf, zero
   assign nan_c  = x_nan | y_nan;
   assign inv_c  = ~nan_c & ((x_inf & y_zero) | (y_inf & x_zero));
   assign inf_c  = ~nan_c & ~inv_c & (x_inf | y_inf);
   assign zero_c = ~nan_c & ~inv_c & ~inf_c & (x_zero | y_zero);

   always_comb begin
      acc_nxt = pm;
      for (int j = 0; j < BITS_PER_CYC; j++) begin
         if (mplr[j]) acc_nxt = acc_nxt + (mcand << j);
      end
      mcand_nxt = mcand << BITS_PER_CYC;
      mplr_nxt  = mplr >> BITS_PER_CYC;
   end

`ifdef FMA16_MUL_EARLY_TERM_EN
   assign last = (cnt == 4'd1) | (mplr_nxt == 11'd0);
`else
   assign last = (cnt == 4'd1);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         mcand     <= 22'd0;
         mplr      <= 11'd0;
         ps        <= 1'b0;
         pe        <= 7'd0;
         pm        <= 22'd0;
         p_zero    <= 1'b0;
         p_inf     <= 1'b0;
         p_nan     <= 1'b0;
         p_invalid <= 1'b0;
      end else if (accept) begin
         ps        <= xs ^ ys ^ negp;
         pe        <= xe_eff + ye_eff - BIAS_W;
         pm        <= 22'd0;
         mcand     <= {11'd0, xsig};
         mplr      <= ysig;
         cnt       <= N_LD;
         p_nan     <= nan_c | inv_c;
         p_invalid <= inv_c;
         p_inf     <= inf_c;
         p_zero    <= zero_c;
         state     <= special ? DONE : BUSY;
      end else if (state == BUSY) begin
         pm    <= acc_nxt;
         mcand <= mcand_nxt;
         mplr  <= mplr_nxt;
         cnt   <= cnt - 4'd1;
         if (last) state <= DONE;
      end else if ((state == DONE) & out_ready) begin
         state <= IDLE;
      end
   end

endmodule
